lsu_bridge: RTL and testbench
=============================

LSU_BRIDGE -- requirements
Module: lsu_bridge

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 0, meaning the max memory wait cycles before an access-fault trap; 0 means no limit.
REQ-002 SHALL have port i_clk, input, 1, global clock.
REQ-003 SHALL have port i_rst, input, 1, reset; one clock, reset synchronous active-high.
REQ-004 SHALL have port i_req_valid, input, 1, pipeline presents an access.
REQ-005 SHALL have port o_req_ready, output, 1, block accepts an access.
REQ-006 SHALL have port i_req_addr, input, 32, byte address.
REQ-007 SHALL have port i_req_wen, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port i_req_funct3, input, 3, RV32I load/store funct3.
REQ-009 SHALL have port i_req_wdata, input, 32, store data, unshifted.
REQ-010 SHALL have port o_rsp_valid, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port o_rsp_rdata, output, 32, extended load result; 0 for stores and traps.
REQ-012 SHALL have port o_rsp_trap, output, 1, misaligned, illegal or timed-out access.
REQ-013 SHALL have ports o_mem_addr (output, 32, word-aligned), o_mem_ren, o_mem_wen (output, 1 each), o_mem_wdata (output, 32, lane-shifted) and o_mem_mask (output, 4, byte lanes).
REQ-014 SHALL have ports i_mem_ready (input, 1, request accepted), i_mem_valid (input, 1, read data valid) and i_mem_rdata (input, 32).

Function
REQ-015 SHALL implement FSM IDLE, REQ, WAIT, RESP; o_req_ready = 1 only in IDLE.
REQ-016 IDLE with i_req_valid SHALL latch addr, wen, funct3 and wdata; a legal access goes to REQ, a trapping access goes to RESP with trap=1 and no memory strobe.
REQ-017 Legal funct3 SHALL be: loads 000, 001, 010, 100, 101; stores 000, 001, 010; all others trap.
REQ-018 REQ SHALL drive exactly one of o_mem_ren/o_mem_wen and hold addr, mask and wdata stable until i_mem_ready=1.
REQ-019 On i_mem_ready in REQ, a store SHALL go to RESP and a load SHALL go to WAIT.
REQ-020 WAIT SHALL deassert strobes; on i_mem_valid it SHALL capture the extended rdata and go to RESP.
REQ-021 RESP SHALL assert o_rsp_valid for exactly one cycle, then go to IDLE.
REQ-022 Minimum latency for a load with ready and valid each arriving on their first eligible cycle SHALL be: accept at N, REQ at N+1, WAIT at N+2, RESP at N+3; a store reaches RESP at N+2.
REQ-023 Mask SHALL be: byte 4'b0001<<addr[1:0]; half 4'b0011 (addr[1]=0) or 4'b1100 (addr[1]=1); word 4'b1111.
REQ-024 o_mem_wdata SHALL be wdata<<(8*addr[1:0]).
REQ-025 Load data SHALL be rdata>>(8*addr[1:0]), then sign-extended (000, 001) or zero-extended (100, 101) from 8 or 16 bits.
REQ-026 A cycle counter SHALL clear on entering REQ and increment in REQ and WAIT.
REQ-027 If WAIT_LIMIT != 0 and the counter reaches WAIT_LIMIT, the block SHALL drop strobes, go to RESP with trap=1, and drop any store.
REQ-028 i_mem_valid outside WAIT SHALL be ignored, including late responses after a timeout.

Reset
REQ-029 On i_rst the block SHALL be in IDLE on the next edge, with o_req_ready=1 and all other outputs 0, including mid-transaction; the in-flight access SHALL be abandoned with no response.

Configuration
REQ-030 With LSU_MISALIGN_TRAP_EN defined, the following SHALL trap without a memory access: half with addr[0]=1, and word with addr[1:0] != 0.
REQ-031 Without LSU_MISALIGN_TRAP_EN, those low address bits SHALL be forced to 0 and the access SHALL proceed with no trap.

Structure
REQ-032 Package lsu_pkg SHALL hold the FSM state encoding and the funct3 constants.
REQ-033 Sub-module lsu_align SHALL hold the combinational mask, write shift and load extension; the FSM and counter SHALL stay in lsu_bridge.

Verification
REQ-034 lb at 0x1003, rdata 0x80FFFFFF -> mask 1000, rsp_rdata 0xFFFFFF80, trap 0.
REQ-035 sh at 0x2002, wdata 0x0000BEEF, ready delayed 3 cycles -> mask 1100, mem_wdata 0xBEEF0000 held 4 cycles, rsp_valid 1 cycle.
REQ-036 lw at 0x1002 -> with LSU_MISALIGN_TRAP_EN: rsp at N+1, trap 1, no ren; without it: mem_addr 0x1000, mask 1111, trap 0.
REQ-037 WAIT_LIMIT=4, load, i_mem_valid never asserted -> trap 1 and rsp_valid after 4 wait cycles; valid injected later is ignored.
REQ-038 i_rst asserted in WAIT -> next cycle IDLE, ready 1, strobes 0, no rsp_valid.
REQ-039 funct3 011 load -> trap 1, rdata 0, no memory strobe.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store bridge: FSM state encoding, RV32I funct3 codes
// and small decode helpers used by lsu_bridge and lsu_align.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic f3_legal(input logic wen, input logic [2:0] funct3);
        if (wen)
            return funct3 inside {F3_B, F3_H, F3_W};
        return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

    // Size lives in funct3[1:0]: 00 byte, 01 half, 10 word.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] lo);
        case (funct3[1:0])
            2'b01:   return lo[0];
            2'b10:   return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] force_align(input logic [2:0] funct3, input logic [1:0] lo);
        case (funct3[1:0])
            2'b01:   return {lo[1], 1'b0};
            2'b10:   return 2'b00;
            default: return lo;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: write mask, store data lane shift and load
// data shift plus sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  mask,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        shifted    = rdata >> {offset, 3'b000};
        wdata_lane = wdata << {offset, 3'b000};
        mask       = 4'b1111;
        load_data  = shifted;
        case (funct3[1:0])
            2'b00: begin
                mask      = 4'b0001 << offset;
                load_data = funct3[2] ? {24'h0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                mask      = offset[1] ? 4'b1100 : 4'b0011;
                load_data = funct3[2] ? {16'h0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
            end
            default: begin
                mask      = 4'b1111;
                load_data = shifted;
            end
        endcase
    end

endmodule

// File: rtl/lsu_bridge.sv
// Single-outstanding load/store bridge between the pipeline and a ready/valid memory port.
// Optional build macro LSU_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of aligning them down.
module lsu_bridge
    import lsu_pkg::*;
#(
    parameter int WAIT_LIMIT = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_wen,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_trap,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_ready,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_rdata
);

    state_t      state, state_next;
    logic [31:0] addr_q;
    logic        wen_q;
    logic [2:0]  f3_q;
    logic [31:0] wdata_q;
    logic [31:0] cnt;
    logic        trap_q;
    logic [31:0] rdata_q;

    logic        acc_trap;
    logic [1:0]  acc_lo;
    logic        timeout;
    logic [3:0]  mask;
    logic [31:0] wdata_lane;
    logic [31:0] load_data;

`ifdef LSU_MISALIGN_TRAP_EN
    assign acc_trap = !f3_legal(i_req_wen, i_req_funct3) || misaligned(i_req_funct3, i_req_addr[1:0]);
    assign acc_lo   = i_req_addr[1:0];
`else
    assign acc_trap = !f3_legal(i_req_wen, i_req_funct3);
    assign acc_lo   = force_align(i_req_funct3, i_req_addr[1:0]);
`endif

    // The counter runs from the first REQ cycle, so the limit covers REQ and WAIT together.
    assign timeout = (WAIT_LIMIT != 0) && (state == ST_REQ || state == ST_WAIT)
                     && (cnt == 32'(WAIT_LIMIT));

    lsu_align u_align (
        .offset     (addr_q[1:0]),
        .funct3     (f3_q),
        .wdata      (wdata_q),
        .rdata      (i_mem_rdata),
        .mask       (mask),
        .wdata_lane (wdata_lane),
        .load_data  (load_data)
    );

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
        if (i_rst) begin
            // NOTE: all registers are reset; outputs are gated by state anyway, but this keeps X out of simulation.
            state   <= ST_IDLE;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            f3_q    <= '0;
            wdata_q <= '0;
            cnt     <= '0;
            trap_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        addr_q  <= {i_req_addr[31:2], acc_lo};
                        wen_q   <= i_req_wen;
                        f3_q    <= i_req_funct3;
                        wdata_q <= i_req_wdata;
                        cnt     <= '0;
                        trap_q  <= acc_trap;
                        rdata_q <= '0;
                    end
                end
                ST_REQ, ST_WAIT: begin
                    cnt <= cnt + 32'd1;
                    if (timeout)
                        trap_q <= 1'b1;
                    else if (state == ST_WAIT && i_mem_valid)
                        rdata_q <= load_data;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next  = state;
        o_req_ready = 1'b0;
        o_mem_ren   = 1'b0;
        o_mem_wen   = 1'b0;
        o_mem_addr  = '0;
        o_mem_mask  = '0;
        o_mem_wdata = '0;
        o_rsp_valid = 1'b0;
        o_rsp_rdata = '0;
        o_rsp_trap  = 1'b0;
        case (state)
            ST_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid)
                    state_next = acc_trap ? ST_RESP : ST_REQ;
            end
            ST_REQ: begin
                o_mem_ren   = !wen_q && !timeout;
                o_mem_wen   = wen_q && !timeout;
                o_mem_addr  = {addr_q[31:2], 2'b00};
                o_mem_mask  = mask;
                o_mem_wdata = wdata_lane;
                if (timeout)
                    state_next = ST_RESP;
                else if (i_mem_ready)
                    state_next = wen_q ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                if (timeout || i_mem_valid)
                    state_next = ST_RESP;
            end
            ST_RESP: begin
                o_rsp_valid = 1'b1;
                o_rsp_rdata = rdata_q;
                o_rsp_trap  = trap_q;
                state_next  = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_bridge.sv
// Self-checking bench for lsu_bridge (WAIT_LIMIT=4): directed corner cases plus
// randomized accesses scored against a cycle-count/arithmetic reference model.
module tb_lsu_bridge;

    localparam int LIMIT = 4;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [31:0] i_req_addr;
    logic        i_req_wen;
    logic [2:0]  i_req_funct3;
    logic [31:0] i_req_wdata;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_trap;
    logic [31:0] o_mem_addr;
    logic        o_mem_ren;
    logic        o_mem_wen;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_mask;
    logic        i_mem_ready;
    logic        i_mem_valid;
    logic [31:0] i_mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 i_clk = ~i_clk;

    lsu_bridge #(.WAIT_LIMIT(LIMIT)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_addr   (i_req_addr),
        .i_req_wen    (i_req_wen),
        .i_req_funct3 (i_req_funct3),
        .i_req_wdata  (i_req_wdata),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_rsp_trap   (o_rsp_trap),
        .o_mem_addr   (o_mem_addr),
        .o_mem_ren    (o_mem_ren),
        .o_mem_wen    (o_mem_wen),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_mask   (o_mem_mask),
        .i_mem_ready  (i_mem_ready),
        .i_mem_valid  (i_mem_valid),
        .i_mem_rdata  (i_mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Architectural view of one access: legality, effective word address, lanes and load value.
    function automatic void model(input logic [31:0] addr, input logic wen, input logic [2:0] f3,
                                  input logic [31:0] wdata, input logic [31:0] rdata,
                                  output logic trap, output logic [31:0] e_addr,
                                  output logic [31:0] e_mask, output logic [31:0] e_wd,
                                  output logic [31:0] e_rd);
        int nb;
        int off;
        logic [31:0] eff;
        logic [31:0] v;
        nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        if (wen) trap = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        else     trap = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((addr % nb) != 0) trap = 1'b1;
        eff = addr;
`else
        eff = addr - (addr % nb);
`endif
        off    = int'(eff % 4);
        e_addr = eff - (eff % 4);
        e_mask = ((32'd1 << nb) - 32'd1) << off;
        e_wd   = wdata << (8 * off);
        v      = rdata >> (8 * off);
        if (nb == 1) begin
            v = v & 32'hFF;
            if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
        end else if (nb == 2) begin
            v = v & 32'hFFFF;
            if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
        end
        e_rd = v;
    endfunction

    // dr: cycles in REQ before i_mem_ready; dv: cycles in WAIT before i_mem_valid.
    task automatic run_access(input string name, input logic [31:0] addr, input logic wen,
                              input logic [2:0] f3, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int dr, input int dv);
        logic        acc_trap;
        logic [31:0] e_addr, e_mask, e_wd, e_rd;
        int          exp_c, exp_strobes;
        logic        exp_trap;
        logic [31:0] exp_rd;
        int          strobes = 0;
        int          bad = 0;
        int          rsp_c = -1;
        logic        got_trap = 1'b0;
        logic [31:0] got_rd = '0;

        model(addr, wen, f3, wdata, rdata, acc_trap, e_addr, e_mask, e_wd, e_rd);
        exp_rd = 32'h0;
        if (acc_trap) begin
            exp_c = 1; exp_trap = 1'b1; exp_strobes = 0;
        end else if (dr >= LIMIT) begin
            exp_c = 2 + LIMIT; exp_trap = 1'b1; exp_strobes = LIMIT;
        end else if (wen) begin
            exp_c = 2 + dr; exp_trap = 1'b0; exp_strobes = dr + 1;
        end else if (1 + dr + dv >= LIMIT) begin
            exp_c = 2 + LIMIT; exp_trap = 1'b1; exp_strobes = dr + 1;
        end else begin
            exp_c = 3 + dr + dv; exp_trap = 1'b0; exp_strobes = dr + 1; exp_rd = e_rd;
        end

        i_req_valid  = 1'b1;
        i_req_addr   = addr;
        i_req_wen    = wen;
        i_req_funct3 = f3;
        i_req_wdata  = wdata;
        i_mem_rdata  = rdata;
        for (int c = 1; c <= 30; c++) begin
            step();
            i_req_valid  = 1'b0;
            i_req_addr   = $urandom;
            i_req_wen    = 1'($urandom);
            i_req_funct3 = 3'($urandom);
            i_req_wdata  = $urandom;
            i_mem_ready  = (c == 1 + dr);
            i_mem_valid  = (c == 2 + dr + dv) || (c <= 1 + dr && $urandom_range(0, 1) == 1);
            if (o_req_ready) bad++;
            if (o_mem_ren || o_mem_wen) begin
                strobes++;
                if (o_mem_wen !== wen || o_mem_ren !== !wen || o_mem_addr !== e_addr ||
                    {28'h0, o_mem_mask} !== e_mask || (wen && o_mem_wdata !== e_wd))
                    bad++;
            end
            if (o_rsp_valid) begin
                rsp_c    = c;
                got_trap = o_rsp_trap;
                got_rd   = o_rsp_rdata;
                break;
            end
        end
        i_mem_ready = 1'b0;
        i_mem_valid = 1'b0;
        step();
        check({name, "_latency"}, 32'(rsp_c), 32'(exp_c));
        check({name, "_trap"}, {31'h0, got_trap}, {31'h0, exp_trap});
        check({name, "_rdata"}, got_rd, exp_rd);
        check({name, "_strobe_cycles"}, 32'(strobes), 32'(exp_strobes));
        check({name, "_mem_side_errors"}, 32'(bad), 32'h0);
        check({name, "_rsp_one_cycle"}, {31'h0, o_rsp_valid}, 32'h0);
        check({name, "_ready_after"}, {31'h0, o_req_ready}, 32'h1);
    endtask

    initial begin
        int hits;
        i_rst = 1'b1;
        i_req_valid = 1'b0; i_req_addr = '0; i_req_wen = 1'b0; i_req_funct3 = '0; i_req_wdata = '0;
        i_mem_ready = 1'b0; i_mem_valid = 1'b0; i_mem_rdata = '0;
        step();
        step();
        i_rst = 1'b0;
        check("reset_ready", {31'h0, o_req_ready}, 32'h1);
        check("reset_outputs", {o_rsp_valid, o_rsp_trap, o_mem_ren, o_mem_wen, o_mem_mask},
              8'h00);
        check("reset_mem_addr", o_mem_addr, 32'h0);
        check("reset_mem_wdata", o_mem_wdata, 32'h0);
        check("reset_rsp_rdata", o_rsp_rdata, 32'h0);

        run_access("lb_1003", 32'h0000_1003, 1'b0, 3'b000, 32'h0, 32'h80FF_FFFF, 0, 0);
        run_access("sh_2002", 32'h0000_2002, 1'b1, 3'b001, 32'h0000_BEEF, 32'h0, 3, 0);
        run_access("lw_1002", 32'h0000_1002, 1'b0, 3'b010, 32'h0, 32'hCAFE_F00D, 0, 0);
        run_access("lbu_2001", 32'h0000_2001, 1'b0, 3'b100, 32'h0, 32'h1234_A5FF, 1, 1);
        run_access("lhu_2003", 32'h0000_2003, 1'b0, 3'b101, 32'h0, 32'h9ABC_5678, 0, 2);
        run_access("sb_3003", 32'h0000_3003, 1'b1, 3'b000, 32'h0000_00A5, 32'h0, 0, 0);
        run_access("f3_011_load", 32'h0000_4000, 1'b0, 3'b011, 32'h0, 32'hFFFF_FFFF, 0, 0);
        run_access("f3_100_store", 32'h0000_4000, 1'b1, 3'b100, 32'h1, 32'h0, 0, 0);
        run_access("store_timeout", 32'h0000_5000, 1'b1, 3'b010, 32'h1111_2222, 32'h0, 9, 0);

        run_access("load_timeout", 32'h0000_3000, 1'b0, 3'b010, 32'h0, 32'h1234_5678, 0, 20);
        hits = 0;
        i_mem_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            if (o_rsp_valid) hits++;
        end
        i_mem_valid = 1'b0;
        check("late_valid_ignored", 32'(hits), 32'h0);

        // Reset while waiting for read data: no response may ever appear for that load.
        i_req_valid = 1'b1; i_req_addr = 32'h0000_6000; i_req_wen = 1'b0; i_req_funct3 = 3'b010;
        i_mem_rdata = 32'hDEAD_BEEF;
        step();
        i_req_valid = 1'b0;
        i_mem_ready = 1'b1;
        step();
        i_mem_ready = 1'b0;
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        check("rst_wait_ready", {31'h0, o_req_ready}, 32'h1);
        check("rst_wait_outputs", {o_rsp_valid, o_rsp_trap, o_mem_ren, o_mem_wen, o_mem_mask},
              8'h00);
        check("rst_wait_rdata", o_rsp_rdata, 32'h0);
        hits = 0;
        i_mem_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            if (o_rsp_valid || !o_req_ready) hits++;
        end
        i_mem_valid = 1'b0;
        check("rst_wait_no_rsp", 32'(hits), 32'h0);

        for (int i = 0; i < 150; i++) begin
            run_access($sformatf("rnd%0d", i), $urandom, 1'($urandom), 3'($urandom),
                       $urandom, $urandom, $urandom_range(0, 5), $urandom_range(0, 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
